mem_line_seq: RTL and testbench
===============================

Name: mem_line_seq

Overview:
- Line-transfer sequencer directly upstream of the word-serial memory controller.
- Accepts one cache-line request (read or write) per transaction from the MSHR/cache side over a valid/ready handshake.
- Drives the controller's op/address/word-bus protocol: serialises write lines into words and assembles read words back into a line.
- Returns a single response per request, with a sticky error flag for controller protocol violations.

Parameters:
- WORD_SIZE, 32: width of the controller's common data bus (one beat).
- CL_SIZE_WIDTH, 512: cache-line width in bits; must be a multiple of WORD_SIZE. Derived: NW = CL_SIZE_WIDTH/WORD_SIZE; IDXW = $clog2(NW).
- ADDR_BITCOUNT, 64: address width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&&req_ready at a clock edge.
- req_write  in  1  1=write line, 0=read line.
- req_addr  in  ADDR_BITCOUNT  byte address of line.
- req_wdata  in  CL_SIZE_WIDTH  write line data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_is_write  out  1  response belongs to a write.
- rsp_rdata  out  CL_SIZE_WIDTH  assembled read line (0 for writes).
- err  out  1  sticky protocol-error flag.
- mc_ready  in  1  controller ready (post-init).
- mc_tx_done  in  1  controller transaction-complete pulse.
- mc_rd_valid  in  1  controller read beat valid.
- mc_op  out  2  00 idle, 01 read, 11 write.
- mc_addr  out  ADDR_BITCOUNT  line-aligned address (raw address to controller).
- mc_wdata  out  WORD_SIZE  write word to controller.
- mc_rdata  in  WORD_SIZE  read word from controller.

Behaviour:
- Word order, both directions: word k = line[(k+1)*WORD_SIZE-1 : k*WORD_SIZE]; word 0 is transferred first.
- States: IDLE, WR_ISSUE, WR_STREAM, WR_WAIT, RD_WAIT, RESP.
- Reset (rst=1 at an edge):
  - state=IDLE, idx=0, err=0, rsp_rdata=0, rsp_is_write=0.
  - Outputs during reset: mc_op=00, req_ready=0, rsp_valid=0, mc_addr=0, mc_wdata=0.
  - Reset mid-transaction aborts it; no response is produced.
- Accept:
  - req_ready = (state==IDLE) && mc_ready && !rst.
  - On accept: latch req_write, req_wdata, and req_addr with its low $clog2(CL_SIZE_WIDTH/8) bits cleared; set idx=0.
  - Read accept also clears rsp_rdata to 0.
  - Next state is WR_ISSUE (write) or RD_WAIT (read).
- mc_op: 11 in WR_ISSUE, WR_STREAM and WR_WAIT; 01 in RD_WAIT; 00 in all other states. mc_op must be 00 in the cycle after mc_tx_done.
- mc_addr: the latched aligned address while a transaction is active.
- Write path:
  - WR_ISSUE lasts exactly 1 cycle and presents word 0; then WR_STREAM.
  - WR_STREAM lasts exactly NW cycles. mc_wdata = word idx; idx increments every cycle. The controller captures word idx at the end of the idx-th WR_STREAM cycle.
  - After the cycle with idx==NW-1: idx wraps to 0, go to WR_WAIT.
  - WR_WAIT: hold mc_op=11 until mc_tx_done=1, then go to RESP with rsp_is_write=1.
- Read path (RD_WAIT):
  - On each mc_rd_valid: rsp_rdata word idx <= mc_rdata; idx++ (saturates at NW-1 once NW beats are stored).
  - On mc_tx_done (may coincide with the last beat, which is still captured): go to RESP, rsp_is_write=0.
  - If fewer than NW beats were captured, including the coincident beat, set err=1. The response is still delivered; missing words read as 0.
- Errors:
  - mc_rd_valid in any state other than RD_WAIT sets err=1 and the beat is ignored.
  - mc_tx_done in IDLE, WR_ISSUE, WR_STREAM or RESP sets err=1 and is otherwise ignored.
  - mc_rd_valid beyond NW beats in one read sets err=1 and is not stored.
  - err is cleared only by rst.
- Response:
  - RESP: rsp_valid=1; rsp_is_write and rsp_rdata held stable until rsp_ready.
  - On handshake: IDLE. Earliest new accept is 1 cycle after the response handshake.
  - No new request is accepted while a response is pending.
- Latency (mc_tx_done in the first WR_WAIT cycle): write accept at edge T, rsp_valid from cycle T+NW+2; read response is valid the cycle after mc_tx_done.
- mc_ready dropping mid-transaction has no effect; it is sampled only for accept.

Test Plan (defaults; NW=16):
1. Reset: hold rst=1 with req_valid=1, mc_ready=1 for 3 cycles -> req_ready=0, mc_op=00, rsp_valid=0, err=0. First accept occurs at the first edge after rst falls.
2. Write: req_addr=0x12345678, word k=0xA0000000+k; controller model asserts tx_done 3 cycles into WR_WAIT.
   - mc_addr=0x12345640; mc_op=11 for 1+16+4 cycles.
   - mc_wdata sequence: 0xA0000000 (issue), then 0xA0000000..0xA000000F.
   - mc_op=00 after tx_done; rsp_valid=1, rsp_is_write=1.
3. Read: model waits 5 cycles, then 16 consecutive rd_valid beats 0xB0+k, with tx_done on beat 15.
   - rsp_rdata word k=0xB0+k; rsp_is_write=0; err=0; mc_op=00 the cycle after tx_done.
4. Backpressure: rsp_ready=0 for 4 cycles with a second req_valid pending -> rsp_valid and rsp_rdata stable, req_ready=0; second request accepted 1 cycle after the handshake.
5. Short read: tx_done on beat 7 (8 beats) -> err=1, rsp_rdata words 0..7 = data, words 8..15 = 0. Stray rd_valid while IDLE keeps err=1.
6. Reset mid-read after 6 beats -> next cycle state IDLE, mc_op=00, rsp_valid=0, err=0, rsp_rdata=0. A fresh read then completes normally.

Source files
------------

// File: rtl/mem_line_seq.sv
// mem_line_seq: cache-line transfer sequencer in front of a word-serial memory controller.
//
// Takes one line request (read or write) per transaction over a valid/ready handshake.
// A write is issued to the controller as one issue beat plus NW streamed words.
// A read is assembled from up to NW returned words. Exactly one response is returned
// per request. err is a sticky flag that records controller protocol violations.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid/ready      request handshake; req_write, req_addr, req_wdata carry the request
//   rsp_valid/ready      response handshake; rsp_is_write, rsp_rdata carry the response
//   err                  sticky protocol-error flag, cleared only by rst
//   mc_ready             controller has finished init; sampled only for accept
//   mc_tx_done           controller transaction-complete pulse
//   mc_rd_valid/rdata    controller read beat
//   mc_op                00 idle, 01 read, 11 write
//   mc_addr, mc_wdata    line-aligned address and current write word
module mem_line_seq #(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned ADDR_BITCOUNT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_BITCOUNT-1:0] req_addr,
  input  logic [CL_SIZE_WIDTH-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_is_write,
  output logic [CL_SIZE_WIDTH-1:0] rsp_rdata,
  output logic                     err,
  input  logic                     mc_ready,
  input  logic                     mc_tx_done,
  input  logic                     mc_rd_valid,
  output logic [1:0]               mc_op,
  output logic [ADDR_BITCOUNT-1:0] mc_addr,
  output logic [WORD_SIZE-1:0]     mc_wdata,
  input  logic [WORD_SIZE-1:0]     mc_rdata
);

  localparam int unsigned NW   = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int unsigned IDXW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned OFFW = $clog2(CL_SIZE_WIDTH / 8);

  localparam logic [IDXW-1:0]          LastIdx   = IDXW'(NW - 1);
  localparam logic [ADDR_BITCOUNT-1:0] AlignMask =
      {{(ADDR_BITCOUNT - OFFW){1'b1}}, {OFFW{1'b0}}};

  localparam logic [1:0] OpIdle  = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrStream,
    StWrWait,
    StRdWait,
    StResp
  } state_e;

  // Lines are held as word arrays so word k sits at bits [(k+1)*WORD_SIZE-1 : k*WORD_SIZE].
  typedef logic [NW-1:0][WORD_SIZE-1:0] line_t;

  state_e                   state_q, state_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic                     rd_full_q, rd_full_d;  // all NW read beats stored
  logic                     err_q, err_d;
  logic                     is_write_q, is_write_d;
  logic [ADDR_BITCOUNT-1:0] addr_q, addr_d;
  line_t                    wdata_q, wdata_d;
  line_t                    rdata_q, rdata_d;

  logic can_accept;

  assign can_accept = (state_q == StIdle) && mc_ready && !rst;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_full_d  = rd_full_q;
    err_d      = err_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    // Stray controller events outside the states that expect them.
    if (mc_rd_valid && (state_q != StRdWait)) begin
      err_d = 1'b1;
    end
    if (mc_tx_done && !((state_q == StWrWait) || (state_q == StRdWait))) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid && can_accept) begin
          addr_d    = req_addr & AlignMask;
          wdata_d   = req_wdata;
          rdata_d   = '0;  // write responses report an all-zero line
          idx_d     = '0;
          rd_full_d = 1'b0;
          state_d   = req_write ? StWrIssue : StRdWait;
        end
      end

      StWrIssue: begin
        state_d = StWrStream;
      end

      StWrStream: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StWrWait;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StWrWait: begin
        if (mc_tx_done) begin
          is_write_d = 1'b1;
          state_d    = StResp;
        end
      end

      StRdWait: begin
        if (mc_rd_valid) begin
          if (rd_full_q) begin
            err_d = 1'b1;  // beat beyond a full line is dropped
          end else begin
            rdata_d[idx_q] = mc_rdata;
            if (idx_q == LastIdx) begin
              rd_full_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        if (mc_tx_done) begin
          // rd_full_d already accounts for a beat coinciding with tx_done.
          if (!rd_full_d) begin
            err_d = 1'b1;
          end
          is_write_d = 1'b0;
          state_d    = StResp;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rd_full_q  <= 1'b0;
      err_q      <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_full_q  <= rd_full_d;
      err_q      <= err_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Outputs; the controller-facing ones are forced idle while rst is high.
  always_comb begin
    req_ready = can_accept;
    rsp_valid = 1'b0;
    mc_op     = OpIdle;
    mc_addr   = '0;
    mc_wdata  = '0;
    if (!rst) begin
      unique case (state_q)
        StWrIssue, StWrStream, StWrWait: begin
          mc_op    = OpWrite;
          mc_wdata = wdata_q[idx_q];
        end
        StRdWait: mc_op = OpRead;
        StResp:   rsp_valid = 1'b1;
        default:  ;
      endcase
      if (state_q != StIdle) begin
        mc_addr = addr_q;
      end
    end
  end

  assign rsp_is_write = is_write_q;
  assign rsp_rdata    = rdata_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_line_seq.sv
// Directed bench for mem_line_seq with the default parameters (32-bit words, 512-bit line).
// The bench drives the controller side by hand and checks each step against
// hand-computed values.
module tb_mem_line_seq;

  localparam int unsigned WS  = 32;
  localparam int unsigned CLW = 512;
  localparam int unsigned AW  = 64;
  localparam int unsigned NW  = CLW / WS;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [AW-1:0]  req_addr;
  logic [CLW-1:0] req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_is_write;
  logic [CLW-1:0] rsp_rdata;
  logic           err;
  logic           mc_ready;
  logic           mc_tx_done;
  logic           mc_rd_valid;
  logic [1:0]     mc_op;
  logic [AW-1:0]  mc_addr;
  logic [WS-1:0]  mc_wdata;
  logic [WS-1:0]  mc_rdata;

  int n_checks;
  int n_fail;

  logic [CLW-1:0] exp_line;

  mem_line_seq #(
    .WORD_SIZE     (WS),
    .CL_SIZE_WIDTH (CLW),
    .ADDR_BITCOUNT (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_is_write (rsp_is_write),
    .rsp_rdata    (rsp_rdata),
    .err          (err),
    .mc_ready     (mc_ready),
    .mc_tx_done   (mc_tx_done),
    .mc_rd_valid  (mc_rd_valid),
    .mc_op        (mc_op),
    .mc_addr      (mc_addr),
    .mc_wdata     (mc_wdata),
    .mc_rdata     (mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CLW-1:0] obs, input logic [CLW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 64'h1234_5678;
    req_wdata   = '0;
    for (int k = 0; k < NW; k++) req_wdata[k*WS +: WS] = 32'hA000_0000 + 32'(k);
    rsp_ready   = 1'b0;
    mc_ready    = 1'b1;
    mc_tx_done  = 1'b0;
    mc_rd_valid = 1'b0;
    mc_rdata    = '0;

    // 1. Reset held for 3 cycles with a request pending.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mc_op", mc_op, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_mc_addr", mc_addr, 0);
      chk("rst_mc_wdata", mc_wdata, 0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    // 2. Write line; accepted at the first edge after reset falls.
    step();
    req_valid = 1'b0;
    chk("wr_issue_op", mc_op, 2'b11);
    chk("wr_issue_addr", mc_addr, 64'h1234_5640);
    chk("wr_issue_wdata", mc_wdata, 32'hA000_0000);
    chk("wr_issue_req_ready", req_ready, 0);
    for (int k = 0; k < NW; k++) begin
      step();
      chk("wr_stream_op", mc_op, 2'b11);
      chk("wr_stream_wdata", mc_wdata, 32'hA000_0000 + 32'(k));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wr_wait_op", mc_op, 2'b11);
      chk("wr_wait_rsp_valid", rsp_valid, 0);
    end
    mc_tx_done = 1'b1;
    step();
    mc_tx_done = 1'b0;
    chk("wr_done_op", mc_op, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_is_write", rsp_is_write, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_err", err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_hs_rsp_valid", rsp_valid, 0);
    chk("wr_hs_req_ready", req_ready, 1);

    // 3. Full read: 5 idle cycles, then 16 back-to-back beats, tx_done on the last.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h0000_0000_0000_1000;
    step();
    req_valid = 1'b0;
    chk("rd_op", mc_op, 2'b01);
    chk("rd_addr", mc_addr, 64'h1000);
    repeat (5) step();
    chk("rd_wait_op", mc_op, 2'b01);
    exp_line = '0;
    for (int k = 0; k < NW; k++) begin
      mc_rd_valid = 1'b1;
      mc_rdata    = 32'hB0 + 32'(k);
      mc_tx_done  = (k == NW - 1);
      exp_line[k*WS +: WS] = 32'hB0 + 32'(k);
      step();
    end
    mc_rd_valid = 1'b0;
    mc_tx_done  = 1'b0;
    chk("rd_done_op", mc_op, 0);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_is_write", rsp_is_write, 0);
    chk("rd_rsp_rdata", rsp_rdata, exp_line);
    chk("rd_err", err, 0);

    // 4. Backpressure with a second (short read) request pending.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h0000_0000_0000_207F;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, exp_line);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_hs_rsp_valid", rsp_valid, 0);
    chk("bp_hs_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("bp_accept_op", mc_op, 2'b01);
    chk("bp_accept_addr", mc_addr, 64'h2040);

    // 5. Short read: 8 beats, tx_done on beat 7.
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      mc_rd_valid = 1'b1;
      mc_rdata    = 32'hC0 + 32'(k);
      mc_tx_done  = (k == 7);
      exp_line[k*WS +: WS] = 32'hC0 + 32'(k);
      step();
    end
    mc_rd_valid = 1'b0;
    mc_tx_done  = 1'b0;
    chk("short_rsp_valid", rsp_valid, 1);
    chk("short_err", err, 1);
    chk("short_rdata", rsp_rdata, exp_line);
    chk("short_op", mc_op, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    mc_rd_valid = 1'b1;
    mc_rdata    = 32'hDEAD_BEEF;
    step();
    mc_rd_valid = 1'b0;
    chk("stray_err_sticky", err, 1);
    chk("stray_op", mc_op, 0);

    // 6. Reset in the middle of a read after 6 beats.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h3000;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mc_rd_valid = 1'b1;
      mc_rdata    = 32'hD0 + 32'(k);
      step();
    end
    mc_rd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_op", mc_op, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_rdata", rsp_rdata, 0);
    chk("midrst_req_ready", req_ready, 1);

    // Fresh read with a gap cycle between beats.
    req_valid = 1'b1;
    req_addr  = 64'h4000;
    step();
    req_valid = 1'b0;
    chk("fresh_op", mc_op, 2'b01);
    exp_line = '0;
    for (int k = 0; k < NW; k++) begin
      mc_rd_valid = 1'b1;
      mc_rdata    = 32'hE0 + 32'(k);
      mc_tx_done  = (k == NW - 1);
      exp_line[k*WS +: WS] = 32'hE0 + 32'(k);
      step();
      mc_rd_valid = 1'b0;
      mc_tx_done  = 1'b0;
      if (k != NW - 1) step();
    end
    chk("fresh_rsp_valid", rsp_valid, 1);
    chk("fresh_rdata", rsp_rdata, exp_line);
    chk("fresh_is_write", rsp_is_write, 0);
    chk("fresh_err", err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("fresh_hs_rsp_valid", rsp_valid, 0);

    // A stray beat while idle raises err.
    mc_rd_valid = 1'b1;
    step();
    mc_rd_valid = 1'b0;
    chk("idle_stray_err", err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
